// File: rtl/mem_wb_pkg.sv
// Shared types and helpers for the memory write buffer.
//   WORD_W      : data / address word width (32)
//   eng_state_t : access engine states IDLE / WR / RD / RSP
//   wb_entry_t  : one buffered store {idx, data}
//   idx_of()    : word address -> RAM index (addr % ram_size, ram_size a power of 2)
package mem_wb_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RSP  = 2'd3
  } eng_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] idx;
    logic [WORD_W-1:0] data;
  } wb_entry_t;

  function automatic logic [WORD_W-1:0] idx_of(input logic [WORD_W-1:0] addr,
                                               input int unsigned       ram_size);
    return addr & (WORD_W'(ram_size) - 1'b1);
  endfunction

endpackage

// File: rtl/mem_write_buffer_fifo.sv
// wb_fifo: synchronous DEPTH-entry FIFO holding buffered stores.
// Optional feature macro: WB_FWD_EN (exposes all entries in age order for
// the store-to-load forwarding search).
// Ports:
//   clk, rst        : clock, synchronous active-high reset (pointers/count only)
//   push, din       : write din at the tail (caller never pushes when full)
//   pop             : drop the head entry (caller never pops when empty)
//   head            : oldest entry
//   full, empty     : occupancy flags
//   entries, vld    : (WB_FWD_EN only) entries[0] = oldest, vld[k] = entry k live
module wb_fifo
  import mem_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t din,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
`ifdef WB_FWD_EN
  ,
  output wb_entry_t [DEPTH-1:0] entries,
  output logic      [DEPTH-1:0] vld
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  // Pointers are exactly PW bits wide, so DEPTH being a power of 2 makes
  // them wrap without explicit modulo logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

`ifdef WB_FWD_EN
  // Rotate storage so index 0 is always the oldest entry; the forwarding
  // search can then treat a higher index as strictly younger.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      entries[k] = mem[rd_ptr + PW'(k)];
      vld[k]     = (CW'(k) < count);
    end
  end
`endif

endmodule

// File: rtl/mem_write_buffer.sv
// mem_write_buffer: backing-memory stage below the direct-mapped cache.
// Buffers write-through stores in a FIFO, drains them into a word-addressed
// RAM, and services single outstanding read-miss fills in program order.
// Optional feature macro: WB_FWD_EN (read hits on buffered stores are
// answered on the next cycle while the FIFO keeps draining).
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid / req_ready         : request handshake (req_ready combinational)
//   req_write, req_addr, req_wdata: 1 = store, word address, store data
//   rsp_valid, rsp_data           : one-cycle fill pulse, data held between pulses
//   busy                          : FIFO non-empty, engine active or read pending
module mem_write_buffer
  import mem_wb_pkg::*;
#(
  parameter int unsigned RAM_SIZE = 4096,
  parameter int          DEPTH    = 4,
  parameter int          LATENCY  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy
);

  localparam int AW    = $clog2(RAM_SIZE);
  localparam int CNT_W = $clog2(LATENCY + 1);

  eng_state_t         state;
  eng_state_t         state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WORD_W-1:0]  wr_idx;
  logic [WORD_W-1:0]  wr_data;
  logic [WORD_W-1:0]  rd_idx;
  logic               rd_pend;
  logic               rd_go;
  logic [WORD_W-1:0]  ram [RAM_SIZE];

  logic [WORD_W-1:0]  req_idx;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               rd_acc;
  logic               ram_we;
  logic               rd_cap;
  logic               rsp_eng;
  wb_entry_t          head;
  wb_entry_t          push_entry;

  assign req_idx    = idx_of(req_addr, RAM_SIZE);
  assign req_ready  = req_write ? (!full && !rd_pend) : !rd_pend;
  assign push       = req_valid && req_ready && req_write;
  assign rd_acc     = req_valid && req_ready && !req_write;
  assign push_entry = '{idx: req_idx, data: req_wdata};

`ifdef WB_FWD_EN
  wb_entry_t [DEPTH-1:0] fifo_entries;
  logic      [DEPTH-1:0] fifo_vld;
  logic                  fwd_hit;
  logic [WORD_W-1:0]     fwd_data;
  logic                  fwd_rsp;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .din     (push_entry),
    .pop     (pop),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .entries (fifo_entries),
    .vld     (fifo_vld)
  );

  // The in-flight WR register is older than anything still in the FIFO,
  // and FIFO index order is oldest-first, so the last match is the youngest.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (state == WR && wr_idx == req_idx) begin
      fwd_hit  = 1'b1;
      fwd_data = wr_data;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (fifo_vld[k] && fifo_entries[k].idx == req_idx) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_entries[k].data;
      end
    end
  end

  // A forwarded read is already answered; keep the engine from fetching it.
  assign rd_go     = rd_pend && !fwd_rsp;
  assign rsp_valid = rsp_eng || fwd_rsp;
`else
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign rd_go     = rd_pend;
  assign rsp_valid = rsp_eng;
`endif

  assign busy = !empty || (state != IDLE) || rd_pend;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Draining wins over a pending read, which keeps reads behind older stores.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!empty)     state_nxt = WR;
        else if (rd_go) state_nxt = RD;
      end
      WR:      if (cnt == '0) state_nxt = IDLE;
      RD:      if (cnt == '0) state_nxt = RSP;
      RSP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop     = (state == IDLE) && !empty;
    ram_we  = (state == WR) && (cnt == '0);
    rd_cap  = (state == RD) && (cnt == '0);
    rsp_eng = (state == RSP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      rd_pend  <= 1'b0;
      rsp_data <= '0;
`ifdef WB_FWD_EN
      fwd_rsp  <= 1'b0;
`endif
    end else begin
      if (state == IDLE && state_nxt != IDLE) cnt <= CNT_W'(LATENCY - 1);
      else if (cnt != '0)                      cnt <= cnt - 1'b1;

      if (rd_acc)       rd_pend <= 1'b1;
`ifdef WB_FWD_EN
      else if (rsp_eng || fwd_rsp) rd_pend <= 1'b0;
      fwd_rsp <= rd_acc && fwd_hit;
`else
      else if (rsp_eng) rd_pend <= 1'b0;
`endif

      if (rd_cap) rsp_data <= ram[rd_idx[AW-1:0]];
`ifdef WB_FWD_EN
      else if (rd_acc && fwd_hit) rsp_data <= fwd_data;
`endif
    end
  end

  // Reset on the commit edge abandons the write rather than completing it.
  always_ff @(posedge clk) begin
    if (pop) begin
      wr_idx  <= head.idx;
      wr_data <= head.data;
    end
    if (rd_acc) rd_idx <= req_idx;
    if (ram_we && !rst) ram[wr_idx[AW-1:0]] <= wr_data;
  end

  // Indices are masked by idx_of, so the bits above AW are always zero.
  logic unused_idx_hi;
  assign unused_idx_hi = ^{wr_idx[WORD_W-1:AW], rd_idx[WORD_W-1:AW]};

endmodule
